// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared types and constants for the instruction fetch stage: word width,
//   fetch FSM states, PC next-value selector, IF/ID register layout and small
//   address helpers used to bound fetches against the instruction memory size.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned COUNT_W = 16;

    typedef logic [XLEN-1:0]    word_t;
    typedef logic [COUNT_W-1:0] count_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP   = 32'd4;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Next-PC source chosen by the fetch controller each cycle.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_ADVANCE  = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_RESTART  = 2'd3
    } pc_sel_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        word_t instr;
        word_t pc4;
        logic  valid;
    } if_id_t;

    // Branch targets are forced onto a word boundary.
    function automatic word_t word_align(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when all four bytes of the word at addr lie inside memory.
    // Evaluated in 33 bits so addresses near 2^32 cannot wrap into range.
    function automatic logic word_fits(input word_t addr, input int unsigned mem_bytes);
        return ({1'b0, addr} + 33'd3) < 33'(mem_bytes);
    endfunction

    // True when addr is at or beyond the end of instruction memory.
    function automatic logic past_end(input word_t addr, input int unsigned mem_bytes);
        return {1'b0, addr} >= 33'(mem_bytes);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the fetch stage's control inputs, instruction-memory port and
//   IF/ID outputs.
//   master : the fetch stage (drives address and the IF/ID outputs)
//   slave  : the environment (control inputs, memory read data)
//   Signals:
//     startin, stall, flush, branch_taken, branch_target  -> fetch stage
//     instruction (combinational memory read data)        -> fetch stage
//     address, if_id_instruction, if_id_pc4, if_id_valid,
//     halted, fetch_count                                 <- fetch stage
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic   startin;
    logic   stall;
    logic   flush;
    logic   branch_taken;
    word_t  branch_target;
    word_t  address;
    word_t  instruction;
    word_t  if_id_instruction;
    word_t  if_id_pc4;
    logic   if_id_valid;
    logic   halted;
    count_t fetch_count;

    modport master (
        input  startin, stall, flush, branch_taken, branch_target, instruction,
        output address, if_id_instruction, if_id_pc4, if_id_valid, halted, fetch_count
    );

    modport slave (
        output startin, stall, flush, branch_taken, branch_target, instruction,
        input  address, if_id_instruction, if_id_pc4, if_id_valid, halted, fetch_count
    );

endinterface

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//   Program counter register with its next-PC multiplexer.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset (PC <= RESET_PC)
//     pc_sel_i     next-PC source: hold, +4, redirect to target, restart
//     target_i     redirect byte address (word-aligned here)
//     pc_o         current PC
//     pc_plus4_o   current PC + 4 (modulo 2^32)
// -----------------------------------------------------------------------------
module pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    rst,
    input  pc_sel_e pc_sel_i,
    input  word_t   target_i,
    output word_t   pc_o,
    output word_t   pc_plus4_o
);

    word_t pc_q;
    word_t pc_d;

    assign pc_plus4_o = pc_q + PC_STEP;
    assign pc_o       = pc_q;

    // NOTE: pc_d gets a default before the case so every path assigns it;
    // a missing assignment in combinational logic would infer a latch.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel_i)
            PC_HOLD:     pc_d = pc_q;
            PC_ADVANCE:  pc_d = pc_plus4_o;
            PC_REDIRECT: pc_d = word_align(target_i);
            PC_RESTART:  pc_d = RESET_PC;
            default:     pc_d = pc_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Instruction fetch stage: IDLE/RUN/HALT controller, IF/ID pipeline register
//   and saturating fetch counter; the PC lives in pc_reg.
//   Parameters:
//     RESET_PC   first fetch address after reset / start
//     MEM_BYTES  instruction memory size; fetching stops at or beyond it
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     fetch_if   instruction_fetch_if.master (controls, memory port, IF/ID)
//   Per-edge priority in RUN: branch_taken > stall > flush > normal advance.
//   A PC that has been redirected outside memory halts on the following edge
//   without touching memory.
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter word_t       RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 40
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master fetch_if
);

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

    fetch_state_e state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    count_t       count_q, count_d;
    pc_sel_e      pc_sel;
    word_t        pc;
    word_t        pc_plus4;
    logic         pc_fetchable;
    logic         next_out_of_range;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .pc_sel_i   (pc_sel),
        .target_i   (fetch_if.branch_target),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    // The current PC may only be captured if its whole word is in memory;
    // after an out-of-range redirect this is what stops the stray read.
    assign pc_fetchable      = word_fits(pc, MEM_BYTES);
    assign next_out_of_range = past_end(pc_plus4, MEM_BYTES);

    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        count_d = count_q;
        pc_sel  = PC_HOLD;

        case (state_q)
            ST_IDLE: begin
                pc_sel  = PC_RESTART;
                if_id_d = IF_ID_BUBBLE;
                if (fetch_if.startin) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!pc_fetchable) begin
                    if_id_d = IF_ID_BUBBLE;
                    state_d = ST_HALT;
                end else if (fetch_if.branch_taken) begin
                    pc_sel  = PC_REDIRECT;
                    if_id_d = IF_ID_BUBBLE;
                end else if (fetch_if.stall) begin
                    // PC and count freeze; a concurrent flush still squashes IF/ID.
                    if (fetch_if.flush) begin
                        if_id_d = IF_ID_BUBBLE;
                    end
                end else begin
                    pc_sel = PC_ADVANCE;
                    if (fetch_if.flush) begin
                        if_id_d = IF_ID_BUBBLE;
                    end else begin
                        if_id_d = '{instr: fetch_if.instruction, pc4: pc_plus4, valid: 1'b1};
                        count_d = (count_q == '1) ? count_q : count_q + count_t'(1);
                    end
                    // The last in-range word is still captured on this edge.
                    if (next_out_of_range) begin
                        state_d = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                if_id_d = IF_ID_BUBBLE;
            end

            default: begin
                state_d = ST_IDLE;
                if_id_d = IF_ID_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            if_id_q <= IF_ID_BUBBLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign fetch_if.address           = pc;
    assign fetch_if.if_id_instruction = if_id_q.instr;
    assign fetch_if.if_id_pc4         = if_id_q.pc4;
    assign fetch_if.if_id_valid       = if_id_q.valid;
    assign fetch_if.halted            = (state_q == ST_HALT);
    assign fetch_if.fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A behavioural model tracks the
//   fetch stage from its rules; directed scenarios cover the documented cases
//   and randomized episodes exercise stall/flush/branch/startin mixes.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam word_t       RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 40;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (bus)
    );

    // Instruction memory: 16 words backing store, combinational read.
    word_t imem [0:15];
    assign bus.instruction = (bus.address < 32'd64) ? imem[bus.address[5:2]] : 32'hBAD0_BAD0;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state.
    int    m_mode;
    word_t m_pc;
    word_t m_instr;
    word_t m_pc4;
    logic  m_valid;
    int    m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = RESET_PC;
        m_count = 0;
        model_bubble();
    endtask

    // One rising edge of the fetch stage, from the written rules.
    task automatic model_edge();
        longint pc_l;
        pc_l = longint'(m_pc);
        if (m_mode == M_IDLE) begin
            m_pc = RESET_PC;
            model_bubble();
            if (bus.startin) m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            model_bubble();
        end else if (pc_l + 3 >= longint'(MEM_BYTES)) begin
            model_bubble();
            m_mode = M_HALT;
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_target & 32'hFFFF_FFFC;
            model_bubble();
        end else if (bus.stall) begin
            if (bus.flush) model_bubble();
        end else begin
            if (bus.flush) begin
                model_bubble();
            end else begin
                m_instr = imem[m_pc / 4];
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                if (m_count < 65535) m_count++;
            end
            m_pc = m_pc + 32'd4;
            if (longint'(m_pc) >= longint'(MEM_BYTES)) m_mode = M_HALT;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " address"},     bus.address,                m_pc);
        check({tag, " instr"},       bus.if_id_instruction,      m_instr);
        check({tag, " pc4"},         bus.if_id_pc4,              m_pc4);
        check({tag, " valid"},       {31'b0, bus.if_id_valid},   {31'b0, m_valid});
        check({tag, " halted"},      {31'b0, bus.halted},        {31'b0, m_mode == M_HALT});
        check({tag, " fetch_count"}, {16'b0, bus.fetch_count},   32'(m_count));
    endtask

    task automatic drive(input logic st, input logic sl, input logic fl,
                         input logic br, input word_t tgt);
        bus.startin       = st;
        bus.stall         = sl;
        bus.flush         = fl;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
    endtask

    // One clock: model follows the edge, outputs sampled 1 unit later,
    // returns at the falling edge ready for new inputs.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    // Reset asserted between edges; its effect must be visible before the
    // next rising edge. Released on a falling edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("in_rst");
        rst = 1'b0;
    endtask

    task automatic start_run();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step("start");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = $urandom();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        step("reset");
        step("reset");
        rst = 1'b0;

        // IDLE ignores branch requests and waits for startin.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        step("idle_branch");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("idle");
        check("idle address", bus.address, 32'h0);

        // Full 40-byte program; startin dropped after the start edge.
        start_run();
        for (int k = 0; k < 10; k++) begin
            step("prog");
            check("prog pc4", bus.if_id_pc4, 32'(4 * (k + 1)));
            check("prog instr", bus.if_id_instruction, imem[k]);
        end
        check("prog count", {16'b0, bus.fetch_count}, 32'd10);
        check("prog halted", {31'b0, bus.halted}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) step("halt_startin");
        check("halt valid", {31'b0, bus.if_id_valid}, 32'd0);
        check("halt address", bus.address, 32'd40);

        // Stall three cycles at PC=8, then resume.
        pulse_reset();
        start_run();
        repeat (2) step("to8");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step("stall");
            check("stall address", bus.address, 32'd8);
            check("stall pc4", bus.if_id_pc4, 32'd8);
            check("stall count", {16'b0, bus.fetch_count}, 32'd2);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("resume");
        check("resume pc4", bus.if_id_pc4, 32'd12);
        check("resume instr", bus.if_id_instruction, imem[2]);

        // Branch with concurrent stall: branch wins, target aligned to 20.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0016);
        step("br_stall");
        check("br_stall address", bus.address, 32'd20);
        check("br_stall valid", {31'b0, bus.if_id_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("after_br");
        check("after_br pc4", bus.if_id_pc4, 32'd24);

        // Flush at PC=12.
        pulse_reset();
        start_run();
        repeat (3) step("to12");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step("flush");
        check("flush address", bus.address, 32'd16);
        check("flush valid", {31'b0, bus.if_id_valid}, 32'd0);
        check("flush count", {16'b0, bus.fetch_count}, 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("after_flush");
        check("after_flush pc4", bus.if_id_pc4, 32'd20);

        // Reset mid-run at PC=24, then stay idle without startin.
        step("to24");
        check("pre_rst address", bus.address, 32'd24);
        pulse_reset();
        check("post_rst count", {16'b0, bus.fetch_count}, 32'd0);
        repeat (3) step("idle_after_rst");
        check("idle_after_rst address", bus.address, 32'd0);

        // Branch beyond memory: bubble, then HALT with no capture.
        start_run();
        repeat (2) step("pre_far");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        step("far_branch");
        check("far address", bus.address, 32'h100);
        check("far halted", {31'b0, bus.halted}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("far_halt");
        check("far_halt halted", {31'b0, bus.halted}, 32'd1);
        repeat (2) step("far_hold");
        check("far_hold valid", {31'b0, bus.if_id_valid}, 32'd0);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 6; ep++) begin
            for (int i = 0; i < 16; i++) imem[i] = $urandom();
            pulse_reset();
            for (int c = 0; c < 45; c++) begin
                logic  st, sl, fl, br;
                word_t tgt;
                st  = ($urandom_range(0, 2) == 0);
                sl  = ($urandom_range(0, 3) == 0);
                fl  = ($urandom_range(0, 4) == 0);
                br  = ($urandom_range(0, 7) == 0);
                tgt = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 47));
                drive(st, sl, fl, br, tgt);
                if ($urandom_range(0, 59) == 0) pulse_reset();
                else step("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
